ysyx_ifu_fetch_ctrl: RTL and testbench
======================================

# ysyx_ifu_fetch_ctrl

Fetch sequencer for the in-order front end. It owns the fetch PC and presents it to the branch predictor and the L1I. It captures each returned instruction with its predicted next PC into a small fetch queue and hands entries to the IDU over a valid/ready handshake. It also handles pipeline redirects and `fence.i` invalidation, including draining an L1I access that is still in flight when a redirect arrives.

## Interface
Parameters:
- `XLEN`, `YSYX_XLEN` (32): PC width.
- `RESET_PC`, 32'h8000_0000: fetch PC after reset.
- `FQ_DEPTH`, 2: fetch queue entries; must be a power of two, ≥2.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  flush request from EXU/commit.
- `redirect_pc`  in  XLEN  new fetch PC; valid with `redirect_valid`.
- `redirect_fence_i`  in  1  redirect also requires L1I invalidation; ignored unless `redirect_valid`.
- `bpu_pc`  out  XLEN  current fetch PC.
- `bpu_npc`  in  XLEN  predicted target.
- `bpu_taken`  in  1  prediction taken; combinational from `bpu_pc`.
- `l1i_pc`  out  XLEN  PC presented to L1I.
- `l1i_invalid`  out  1  one-cycle invalidate-all pulse.
- `l1i_inst`  in  32  instruction at `l1i_pc`.
- `l1i_valid`  in  1  `l1i_inst` valid this cycle.
- `idu_inst`  out  32  head-entry instruction.
- `idu_pc`  out  XLEN  head-entry PC.
- `idu_pnpc`  out  XLEN  head-entry predicted next PC.
- `idu_valid`  out  1  queue non-empty.
- `idu_ready`  in  1  IDU accepts head this cycle.

## Operation
- L1I contract: `l1i_pc` is held stable from first presentation until the cycle `l1i_valid`=1. L1I may return in the same cycle (hit) or later (miss).
- `pnpc` = `bpu_taken` ? `bpu_npc` : `pc`+4, with XLEN-bit wrap-around (no overflow detection).
- FSM states:
  - FETCH: `l1i_pc`=`bpu_pc`=`pc`.
  - KILL: drain the stale L1I access. `l1i_pc` holds the old PC; `bpu_pc` is don't-care.
  - FENCE: `l1i_invalid`=1 for exactly this cycle.
- Push happens when FETCH ∧ `l1i_valid` ∧ ¬`redirect_valid` ∧ (count<FQ_DEPTH ∨ `idu_ready`). A push writes {`l1i_inst`, `pc`, `pnpc`} and sets `pc`←`pnpc`.
- If FETCH ∧ `l1i_valid` ∧ queue full ∧ ¬`idu_ready`, the response is not consumed. `pc` holds and L1I keeps `l1i_valid` asserted; the team's L1I holds its output while its PC is stable.
- Pop happens when `idu_valid` ∧ `idu_ready`. Simultaneous push and pop on a full queue is legal and leaves the count unchanged.
- `redirect_valid` has the highest priority:
  - Queue is cleared.
  - `pending_pc`←`redirect_pc` and `pending_fence`←`redirect_fence_i`.
  - From FETCH with `l1i_valid`=1 in the same cycle, or from FETCH with the queue-full stall: the response is dropped. Next state is FENCE if fence, else FETCH with `pc`←`redirect_pc`.
  - From FETCH with `l1i_valid`=0: go to KILL, since an L1I access may be in flight.
  - In KILL: on `l1i_valid`=1, drop the response. Go to FENCE if `pending_fence`, else go to FETCH with `pc`←`pending_pc`.
  - A redirect arriving during KILL overwrites `pending_pc`/`pending_fence` (fence bits OR together) and stays in KILL.
  - A redirect arriving during FENCE overwrites pending and stays in FENCE for one more cycle.
- FENCE always exits to FETCH with `pc`←`pending_pc`.

## Timing
- Reset values: `pc`=RESET_PC, state FETCH, queue empty, `idu_valid`=0, `l1i_invalid`=0, pending cleared. `bpu_pc`/`l1i_pc`=RESET_PC.
- Outputs are registered or decode straight from registers. `bpu_pc`/`l1i_pc` are driven from the `pc` register. IDU outputs come from the queue head.
- Throughput with a same-cycle L1I hit and IDU always ready: one instruction per cycle. An entry pushed at cycle t is visible on IDU outputs at t+1.
- Redirect at cycle t: `idu_valid`=0 at t+1.
  - L1I response at t: FETCH at t+1 with the new PC.
  - KILL path: new PC appears the cycle after the drained `l1i_valid`.
  - Fence adds one FENCE cycle.
- Reset asserted mid-miss or mid-KILL returns to reset values immediately. L1I is responsible for aborting its own access.

## Structure
- Shared package holds the state enum and the queue entry struct: inst[31:0], pc, pnpc.
- The fetch queue is a natural sub-module, `ysyx_ifu_fq`: parameterised FIFO with a synchronous flush input, reused by later front-end work.

## Test plan
- Reset release with L1I always hitting and `idu_ready`=1: `idu_pc` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles, `pnpc`=pc+4.
- `bpu_taken`=1 and `bpu_npc`=0x8000_0100 at pc 0x8000_0008: entry has `pnpc`=0x8000_0100, and the next entry has pc 0x8000_0100.
- `idu_ready`=0 for 5 cycles: exactly FQ_DEPTH entries held and `pc` frozen. When ready rises, entries drain in order with no loss or duplication.
- L1I miss of 4 cycles at 0x8000_0010, redirect to 0x8000_0200 at cycle 1 of the miss: stale instruction is never presented. First `idu_pc` after the drain is 0x8000_0200.
- Redirect with `redirect_fence_i`=1 to 0x8000_0040 while idle in FETCH: `l1i_invalid` is high for exactly one cycle, then fetch resumes at 0x8000_0040.
- Second redirect (0x8000_0300) during KILL of a first (0x8000_0200): only 0x8000_0300 is fetched.

Source files
------------

// File: rtl/ysyx_ifu_fetch_ctrl_pkg.sv
// Shared types for the IFU fetch sequencer.
// Holds the FSM state encoding and the fetch-queue entry layout.
package ysyx_ifu_fetch_ctrl_pkg;

  localparam int unsigned YSYX_XLEN = 32;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_KILL  = 2'd1,
    ST_FENCE = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]          inst;
    logic [YSYX_XLEN-1:0] pc;
    logic [YSYX_XLEN-1:0] pnpc;
  } fq_entry_t;

endpackage

// File: rtl/ysyx_ifu_fetch_ctrl_fq.sv
// Fetch queue: power-of-two FIFO with synchronous flush.
// Head entry is always visible on data_o; flush wins over push/pop.
module ysyx_ifu_fq #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 96
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // a full queue may still accept when the head leaves this cycle
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ysyx_ifu_fetch_ctrl.sv
// IFU fetch sequencer: owns the fetch PC, fills the fetch queue
// from L1I and handles redirects, stale-access drain and fence.i.
module ysyx_ifu_fetch_ctrl
  import ysyx_ifu_fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = YSYX_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_fence_i,
  output logic [XLEN-1:0] bpu_pc,
  input  logic [XLEN-1:0] bpu_npc,
  input  logic            bpu_taken,
  output logic [XLEN-1:0] l1i_pc,
  output logic            l1i_invalid,
  input  logic [31:0]     l1i_inst,
  input  logic            l1i_valid,
  output logic [31:0]     idu_inst,
  output logic [XLEN-1:0] idu_pc,
  output logic [XLEN-1:0] idu_pnpc,
  output logic            idu_valid,
  input  logic            idu_ready
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_fence_q, pend_fence_d;
  logic [XLEN-1:0] pnpc;
  logic            fq_full;
  logic            fq_empty;
  logic            push;
  logic            pop;
  fq_entry_t       push_ent;
  fq_entry_t       head_ent;

  assign pnpc = bpu_taken ? bpu_npc : pc_q + XLEN'(4);

  // pc_q is not advanced in KILL/FENCE, so it still holds the
  // address of the access being drained
  assign bpu_pc      = pc_q;
  assign l1i_pc      = pc_q;
  assign l1i_invalid = (state_q == ST_FENCE);

  assign idu_valid = ~fq_empty;
  assign pop       = idu_valid & idu_ready;
  assign push      = (state_q == ST_FETCH) & l1i_valid
                   & ~redirect_valid & (~fq_full | idu_ready);

  assign push_ent = '{inst: l1i_inst, pc: pc_q, pnpc: pnpc};

  assign idu_inst = head_ent.inst;
  assign idu_pc   = head_ent.pc;
  assign idu_pnpc = head_ent.pnpc;

  ysyx_ifu_fq #(
    .DEPTH (FQ_DEPTH),
    .W     ($bits(fq_entry_t))
  ) u_fq (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_ent),
    .pop_i   (pop),
    .data_o  (head_ent),
    .full_o  (fq_full),
    .empty_o (fq_empty)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_fence_d = pend_fence_q;
    unique case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          pend_pc_d    = redirect_pc;
          pend_fence_d = redirect_fence_i;
          unique case (1'b1)
            !l1i_valid:       state_d = ST_KILL;
            redirect_fence_i: state_d = ST_FENCE;
            default:          pc_d    = redirect_pc;
          endcase
        end else if (push) begin
          pc_d = pnpc;
        end
      end
      ST_KILL: begin
        if (redirect_valid) begin
          pend_pc_d    = redirect_pc;
          pend_fence_d = pend_fence_q | redirect_fence_i;
        end
        // the drained response closes the only access in flight
        if (l1i_valid) begin
          if (pend_fence_d) begin
            state_d = ST_FENCE;
          end else begin
            state_d = ST_FETCH;
            pc_d    = pend_pc_d;
          end
        end
      end
      ST_FENCE: begin
        if (redirect_valid) begin
          pend_pc_d    = redirect_pc;
          pend_fence_d = redirect_fence_i;
        end else begin
          state_d = ST_FETCH;
          pc_d    = pend_pc_q;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      pend_fence_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_fence_q <= pend_fence_d;
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_fetch_ctrl.sv
// Directed bench for ysyx_ifu_fetch_ctrl with small L1I/BPU models.
// Expected PCs and instructions are hand-computed constants.
module tb_ysyx_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] IKEY   = 32'h5A5A_0013;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_fence_i;
  logic [31:0] bpu_pc;
  logic [31:0] bpu_npc;
  logic        bpu_taken;
  logic [31:0] l1i_pc;
  logic        l1i_invalid;
  logic [31:0] l1i_inst;
  logic        l1i_valid;
  logic [31:0] idu_inst;
  logic [31:0] idu_pc;
  logic [31:0] idu_pnpc;
  logic        idu_valid;
  logic        idu_ready;

  int checks;
  int fails;

  // BPU predicts a single taken branch; L1I data is a PC hash
  assign bpu_taken = (bpu_pc == 32'h8000_0008);
  assign bpu_npc   = 32'h8000_0100;
  assign l1i_inst  = l1i_pc ^ IKEY;

  ysyx_ifu_fetch_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_fence_i (redirect_fence_i),
    .bpu_pc           (bpu_pc),
    .bpu_npc          (bpu_npc),
    .bpu_taken        (bpu_taken),
    .l1i_pc           (l1i_pc),
    .l1i_invalid      (l1i_invalid),
    .l1i_inst         (l1i_inst),
    .l1i_valid        (l1i_valid),
    .idu_inst         (idu_inst),
    .idu_pc           (idu_pc),
    .idu_pnpc         (idu_pnpc),
    .idu_valid        (idu_valid),
    .idu_ready        (idu_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    redirect_fence_i = 1'b0;
    l1i_valid        = 1'b0;
    idu_ready        = 1'b1;
    repeat (3) tick();
    checks++;
    if (idu_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid: got %b want 0", idu_valid);
    end
    checks++;
    if (bpu_pc !== RST_PC) begin
      fails++;
      $display("FAIL rst_bpu_pc: got %h want %h", bpu_pc, RST_PC);
    end
    checks++;
    if (l1i_pc !== RST_PC) begin
      fails++;
      $display("FAIL rst_l1i_pc: got %h want %h", l1i_pc, RST_PC);
    end
    checks++;
    if (l1i_invalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_inval: got %b want 0", l1i_invalid);
    end
  endtask

  task automatic test_stream_and_taken();
    logic [31:0] ep [4];
    logic [31:0] en [4];
    ep[0] = 32'h8000_0000; en[0] = 32'h8000_0004;
    ep[1] = 32'h8000_0004; en[1] = 32'h8000_0008;
    ep[2] = 32'h8000_0008; en[2] = 32'h8000_0100;
    ep[3] = 32'h8000_0100; en[3] = 32'h8000_0104;
    reset     = 1'b1;
    l1i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (idu_valid !== 1'b1 || idu_pc !== ep[i]) begin
        fails++;
        $display("FAIL stream_pc%0d: got v=%b %h want %h",
                 i, idu_valid, idu_pc, ep[i]);
      end
      checks++;
      if (idu_pnpc !== en[i]) begin
        fails++;
        $display("FAIL stream_pnpc%0d: got %h want %h",
                 i, idu_pnpc, en[i]);
      end
      checks++;
      if (idu_inst !== (ep[i] ^ IKEY)) begin
        fails++;
        $display("FAIL stream_inst%0d: got %h want %h",
                 i, idu_inst, ep[i] ^ IKEY);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ep [4];
    ep[0] = 32'h8000_0100;
    ep[1] = 32'h8000_0104;
    ep[2] = 32'h8000_0108;
    ep[3] = 32'h8000_010C;
    idu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (idu_valid !== 1'b1 || idu_pc !== 32'h8000_0100) begin
        fails++;
        $display("FAIL stall_head%0d: got v=%b %h want 80000100",
                 i, idu_valid, idu_pc);
      end
      checks++;
      if (bpu_pc !== 32'h8000_0108) begin
        fails++;
        $display("FAIL stall_pc%0d: got %h want 80000108",
                 i, bpu_pc);
      end
    end
    idu_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (idu_valid !== 1'b1 || idu_pc !== ep[i]) begin
        fails++;
        $display("FAIL drain%0d: got v=%b %h want %h",
                 i, idu_valid, idu_pc, ep[i]);
      end
    end
  endtask

  task automatic test_miss_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0010;
    l1i_valid      = 1'b1;
    tick();
    checks++;
    if (idu_valid !== 1'b0 || bpu_pc !== 32'h8000_0010) begin
      fails++;
      $display("FAIL redir_hit: got v=%b pc=%h want 0 80000010",
               idu_valid, bpu_pc);
    end
    redirect_valid = 1'b0;
    l1i_valid      = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (idu_valid !== 1'b0 || l1i_pc !== 32'h8000_0010) begin
      fails++;
      $display("FAIL kill_hold: got v=%b l1i=%h want 0 80000010",
               idu_valid, l1i_pc);
    end
    tick();
    l1i_valid = 1'b1;
    tick();
    checks++;
    if (idu_valid !== 1'b0 || bpu_pc !== 32'h8000_0200) begin
      fails++;
      $display("FAIL kill_exit: got v=%b pc=%h want 0 80000200",
               idu_valid, bpu_pc);
    end
    tick();
    checks++;
    if (idu_valid !== 1'b1 || idu_pc !== 32'h8000_0200) begin
      fails++;
      $display("FAIL kill_first: got v=%b %h want 80000200",
               idu_valid, idu_pc);
    end
    checks++;
    if (idu_inst !== (32'h8000_0200 ^ IKEY)) begin
      fails++;
      $display("FAIL kill_inst: got %h want %h",
               idu_inst, 32'h8000_0200 ^ IKEY);
    end
  endtask

  task automatic test_fence();
    redirect_valid   = 1'b1;
    redirect_fence_i = 1'b1;
    redirect_pc      = 32'h8000_0040;
    tick();
    redirect_valid   = 1'b0;
    redirect_fence_i = 1'b0;
    checks++;
    if (l1i_invalid !== 1'b1 || idu_valid !== 1'b0) begin
      fails++;
      $display("FAIL fence_on: got inv=%b v=%b want 1 0",
               l1i_invalid, idu_valid);
    end
    tick();
    checks++;
    if (l1i_invalid !== 1'b0 || bpu_pc !== 32'h8000_0040) begin
      fails++;
      $display("FAIL fence_off: got inv=%b pc=%h want 0 80000040",
               l1i_invalid, bpu_pc);
    end
    tick();
    checks++;
    if (idu_valid !== 1'b1 || idu_pc !== 32'h8000_0040) begin
      fails++;
      $display("FAIL fence_fetch: got v=%b %h want 80000040",
               idu_valid, idu_pc);
    end
    checks++;
    if (l1i_invalid !== 1'b0) begin
      fails++;
      $display("FAIL fence_once: got %b want 0", l1i_invalid);
    end
  endtask

  task automatic test_double_redirect();
    l1i_valid = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    checks++;
    if (idu_valid !== 1'b0 || l1i_pc !== 32'h8000_0044) begin
      fails++;
      $display("FAIL dbl_kill: got v=%b l1i=%h want 0 80000044",
               idu_valid, l1i_pc);
    end
    redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    l1i_valid      = 1'b1;
    checks++;
    if (l1i_pc !== 32'h8000_0044) begin
      fails++;
      $display("FAIL dbl_hold: got %h want 80000044", l1i_pc);
    end
    tick();
    checks++;
    if (bpu_pc !== 32'h8000_0300 || idu_valid !== 1'b0) begin
      fails++;
      $display("FAIL dbl_exit: got pc=%h v=%b want 80000300 0",
               bpu_pc, idu_valid);
    end
    tick();
    checks++;
    if (idu_valid !== 1'b1 || idu_pc !== 32'h8000_0300) begin
      fails++;
      $display("FAIL dbl_first: got v=%b %h want 80000300",
               idu_valid, idu_pc);
    end
    checks++;
    if (idu_pnpc !== 32'h8000_0304) begin
      fails++;
      $display("FAIL dbl_pnpc: got %h want 80000304", idu_pnpc);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (idu_pc !== 32'hFFFF_FFFC || idu_pnpc !== 32'h0) begin
      fails++;
      $display("FAIL wrap_pnpc: got pc=%h pnpc=%h want fffffffc 0",
               idu_pc, idu_pnpc);
    end
    tick();
    checks++;
    if (idu_valid !== 1'b1 || idu_pc !== 32'h0) begin
      fails++;
      $display("FAIL wrap_next: got v=%b %h want 00000000",
               idu_valid, idu_pc);
    end
  endtask

  task automatic test_reset_in_kill();
    l1i_valid      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0500;
    tick();
    redirect_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bpu_pc !== RST_PC || idu_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: got pc=%h v=%b want %h 0",
               bpu_pc, idu_valid, RST_PC);
    end
    tick();
    reset     = 1'b1;
    l1i_valid = 1'b1;
    tick();
    checks++;
    if (idu_valid !== 1'b1 || idu_pc !== RST_PC) begin
      fails++;
      $display("FAIL rst_restart: got v=%b %h want %h",
               idu_valid, idu_pc, RST_PC);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_stream_and_taken();
    test_backpressure();
    test_miss_redirect();
    test_fence();
    test_double_redirect();
    test_wrap();
    test_reset_in_kill();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
